// File: rtl/jk_pkg.sv
// Shared types and the golden JK next-state function, used by the checker and the bench.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_e;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        ARMED  = 2'd1,
        HALT   = 2'd2
    } chk_state_e;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        jk_cmd_e cmd;
        cmd = jk_cmd_e'({j, k});
        case (cmd)
            JK_HOLD:   return q;
            JK_RESET:  return 1'b0;
            JK_SET:    return 1'b1;
            JK_TOGGLE: return ~q;
            default:   return q;
        endcase
    endfunction

endpackage

// File: rtl/jk_ff_checker.sv
// On-chip checker for a JK flip-flop: predicts each q from the previous sample
// and reports mismatches, a sticky error flag and saturating counters.
module jk_ff_checker
    import jk_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    output logic             pred_q,
    output logic             mismatch,
    output logic             err,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [1:0]       state
);

    chk_state_e       state_q, state_d;
    logic             j_cap_q, j_cap_d;
    logic             k_cap_q, k_cap_d;
    logic             q_cap_q, q_cap_d;
    logic             mismatch_q, mismatch_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Prediction is anchored on the observed q, so one DUT fault yields one mismatch.
    assign pred_q = jk_next(q_cap_q, j_cap_q, k_cap_q);

    always_comb begin
        state_d         = state_q;
        j_cap_d         = j_cap_q;
        k_cap_d         = k_cap_q;
        q_cap_d         = q_cap_q;
        mismatch_d      = 1'b0;
        err_d           = err_q;
        sample_cnt_d    = sample_cnt_q;
        err_cnt_d       = err_cnt_q;
        first_err_idx_d = first_err_idx_q;

        if (clr) begin
            state_d         = UNSYNC;
            j_cap_d         = 1'b0;
            k_cap_d         = 1'b0;
            q_cap_d         = 1'b0;
            err_d           = 1'b0;
            sample_cnt_d    = '0;
            err_cnt_d       = '0;
            first_err_idx_d = '0;
        end else if (en) begin
            case (state_q)
                UNSYNC: begin
                    j_cap_d = j;
                    k_cap_d = k;
                    q_cap_d = q;
                    state_d = ARMED;
                end
                ARMED: begin
                    sample_cnt_d = sat_inc(sample_cnt_q);
                    if (q != pred_q) begin
                        mismatch_d = 1'b1;
                        err_d      = 1'b1;
                        err_cnt_d  = sat_inc(err_cnt_q);
                        if (!err_q) begin
                            first_err_idx_d = sample_cnt_q;
                        end
                        if (STOP_ON_ERR) begin
                            state_d = HALT;
                        end
                    end
                    j_cap_d = j;
                    k_cap_d = k;
                    q_cap_d = q;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= UNSYNC;
            j_cap_q         <= 1'b0;
            k_cap_q         <= 1'b0;
            q_cap_q         <= 1'b0;
            mismatch_q      <= 1'b0;
            err_q           <= 1'b0;
            sample_cnt_q    <= '0;
            err_cnt_q       <= '0;
            first_err_idx_q <= '0;
        end else begin
            state_q         <= state_d;
            j_cap_q         <= j_cap_d;
            k_cap_q         <= k_cap_d;
            q_cap_q         <= q_cap_d;
            mismatch_q      <= mismatch_d;
            err_q           <= err_d;
            sample_cnt_q    <= sample_cnt_d;
            err_cnt_q       <= err_cnt_d;
            first_err_idx_q <= first_err_idx_d;
        end
    end

    assign mismatch      = mismatch_q;
    assign err           = err_q;
    assign sample_cnt    = sample_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_idx_q;
    assign state         = state_q;

endmodule

// File: tb/tb_jk_ff_checker.sv
// Bench for jk_ff_checker: the bench plays the JK DUT and scoreboards per-sample results.
module tb_jk_ff_checker;
    import jk_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic j = 1'b0;
    logic k = 1'b0;
    logic q = 1'b0;

    logic        m_pred_q, m_mismatch, m_err;
    logic [15:0] m_sample_cnt, m_err_cnt, m_first_err_idx;
    logic [1:0]  m_state;
    logic        s_pred_q, s_mismatch, s_err;
    logic [15:0] s_sample_cnt, s_err_cnt, s_first_err_idx;
    logic [1:0]  s_state;
    logic        c_pred_q, c_mismatch, c_err;
    logic [3:0]  c_sample_cnt, c_err_cnt, c_first_err_idx;
    logic [1:0]  c_state;

    always #5 clk = ~clk;

    jk_ff_checker #(.CNT_W(16), .STOP_ON_ERR(1'b0)) u_main (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .j(j), .k(k), .q(q),
        .pred_q(m_pred_q), .mismatch(m_mismatch), .err(m_err), .sample_cnt(m_sample_cnt),
        .err_cnt(m_err_cnt), .first_err_idx(m_first_err_idx), .state(m_state));

    jk_ff_checker #(.CNT_W(16), .STOP_ON_ERR(1'b1)) u_stop (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .j(j), .k(k), .q(q),
        .pred_q(s_pred_q), .mismatch(s_mismatch), .err(s_err), .sample_cnt(s_sample_cnt),
        .err_cnt(s_err_cnt), .first_err_idx(s_first_err_idx), .state(s_state));

    jk_ff_checker #(.CNT_W(4), .STOP_ON_ERR(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .j(j), .k(k), .q(q),
        .pred_q(c_pred_q), .mismatch(c_mismatch), .err(c_err), .sample_cnt(c_sample_cnt),
        .err_cnt(c_err_cnt), .first_err_idx(c_first_err_idx), .state(c_state));

    typedef struct {
        logic mis;
        logic pred;
        logic armed;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Bench-side JK model: mq is the DUT's real q, pj/pk/pq the checker's captures.
    logic mq = 1'b0;
    logic pj = 1'b0, pk = 1'b0, pq = 1'b0;
    logic armed = 1'b0;
    logic [1:0] cmds [0:6] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        armed = 1'b0;
        pj = 1'b0;
        pk = 1'b0;
        pq = 1'b0;
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    // fault: 0 = correct DUT, 1 = q inverted this sample, 2 = q stuck at 0
    task automatic step(input logic jj, input logic kk, input logic ee, input int fault);
        exp_t e;
        logic qd;
        @(negedge clk);
        qd = (fault == 1) ? ~mq : ((fault == 2) ? 1'b0 : mq);
        j  = jj;
        k  = kk;
        q  = qd;
        en = ee;
        e.mis = ee && armed && (qd != jk_next(pq, pj, pk));
        if (ee) begin
            pj    = jj;
            pk    = kk;
            pq    = qd;
            armed = 1'b1;
            mq    = jk_next(qd, jj, kk);
        end
        e.pred  = jk_next(pq, pj, pk);
        e.armed = armed;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("mismatch", 32'(m_mismatch), 32'(e.mis));
        if (e.armed) chk("pred_q", 32'(m_pred_q), 32'(e.pred));
    endtask

    task automatic clr_step();
        exp_t e;
        @(negedge clk);
        clr = 1'b1;
        en  = 1'b1;
        model_reset();
        e.mis = 1'b0;
        e.pred = 1'b0;
        e.armed = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("clr_mismatch", 32'(m_mismatch), 32'(e.mis));
        clr = 1'b0;
        en  = 1'b0;
    endtask

    initial begin
        // Reset values and the UNSYNC capture
        #12;
        chk("rst_state", 32'(m_state), 0);
        chk("rst_pred", 32'(m_pred_q), 0);
        chk("rst_err", 32'(m_err), 0);
        chk("rst_cnt", 32'(m_sample_cnt), 0);
        chk("rst_errcnt", 32'(m_err_cnt), 0);
        chk("rst_first", 32'(m_first_err_idx), 0);
        rst_n = 1'b1;
        model_reset();
        mq = 1'b1;
        step(1'b1, 1'b0, 1'b1, 0);
        chk("t1_state", 32'(m_state), 1);
        chk("t1_cnt", 32'(m_sample_cnt), 0);
        chk("t1_err", 32'(m_err), 0);

        // Correct DUT, 20 compared samples
        reset_all();
        for (int i = 0; i <= 20; i++) step(cmds[i % 7][1], cmds[i % 7][0], 1'b1, 0);
        chk("t2_cnt", 32'(m_sample_cnt), 20);
        chk("t2_errcnt", 32'(m_err_cnt), 0);
        chk("t2_err", 32'(m_err), 0);

        // Single inverted q on sample 5
        reset_all();
        for (int i = 0; i <= 10; i++) step(cmds[i % 7][1], cmds[i % 7][0], 1'b1, (i == 6) ? 1 : 0);
        chk("t3_err", 32'(m_err), 1);
        chk("t3_errcnt", 32'(m_err_cnt), 1);
        chk("t3_first", 32'(m_first_err_idx), 5);
        chk("t3_cnt", 32'(m_sample_cnt), 10);

        // STOP_ON_ERR instance halts on fault at sample 3
        reset_all();
        for (int i = 0; i <= 8; i++) step(cmds[i % 7][1], cmds[i % 7][0], 1'b1, (i == 4) ? 1 : 0);
        chk("t4_state", 32'(s_state), 2);
        chk("t4_cnt", 32'(s_sample_cnt), 4);
        chk("t4_errcnt", 32'(s_err_cnt), 1);
        chk("t4_first", 32'(s_first_err_idx), 3);
        chk("t4_main_cnt", 32'(m_sample_cnt), 8);
        clr_step();
        chk("t4_clr_state", 32'(s_state), 0);
        chk("t4_clr_cnt", 32'(s_sample_cnt), 0);
        chk("t4_clr_errcnt", 32'(s_err_cnt), 0);
        chk("t4_clr_err", 32'(s_err), 0);
        chk("t4_clr_first", 32'(s_first_err_idx), 0);

        // Saturation with CNT_W=4, q stuck at 0 under TOGGLE
        reset_all();
        for (int i = 0; i <= 30; i++) step(1'b1, 1'b1, 1'b1, 2);
        chk("t5_errcnt", 32'(c_err_cnt), 15);
        chk("t5_cnt", 32'(c_sample_cnt), 15);
        chk("t5_err", 32'(c_err), 1);
        chk("t5_first", 32'(c_first_err_idx), 0);

        // en=0 hold, then asynchronous reset between edges
        reset_all();
        for (int i = 0; i <= 5; i++) step(cmds[i % 7][1], cmds[i % 7][0], 1'b1, (i == 3) ? 1 : 0);
        for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0);
        chk("t6_hold_cnt", 32'(m_sample_cnt), 5);
        chk("t6_hold_errcnt", 32'(m_err_cnt), 1);
        chk("t6_hold_state", 32'(m_state), 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_state", 32'(m_state), 0);
        chk("t6_arst_cnt", 32'(m_sample_cnt), 0);
        chk("t6_arst_err", 32'(m_err), 0);
        chk("t6_arst_errcnt", 32'(m_err_cnt), 0);
        chk("t6_arst_first", 32'(m_first_err_idx), 0);
        chk("t6_arst_pred", 32'(m_pred_q), 0);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b1, 1'b1, 0);
        chk("t6_resync_state", 32'(m_state), 1);
        chk("t6_resync_cnt", 32'(m_sample_cnt), 0);
        step(1'b1, 1'b1, 1'b1, 0);
        chk("t6_after_cnt", 32'(m_sample_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
